// File: rtl/axis_frame_checker.sv
// axis_frame_checker: skid-buffered AXIS pass-through with frame framing checks.
// Define FRAME_CHECKSUM_EN to get a per-frame pixel sum on frame_checksum.
module axis_frame_checker #(
  parameter int WIDTH      = 128,
  parameter int HEIGHT     = 100,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  input  logic                  clear_err,
  output logic [3:0]            err_flags,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic [15:0]           frame_count,
  output logic [31:0]           frame_checksum
);
  localparam int N  = WIDTH * HEIGHT;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, FRAME} state_t;

  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_last;
  logic                  skid_user;
  logic                  accept;
  logic                  out_take;

  // Ready depends only on the skid register, never on m_axis_tready.
  assign s_axis_tready = !skid_valid && !rst;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign out_take      = !m_axis_tvalid || m_axis_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      skid_valid    <= 1'b0;
      skid_data     <= '0;
      skid_last     <= 1'b0;
      skid_user     <= 1'b0;
    end else if (out_take) begin
      if (skid_valid) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= skid_data;
        m_axis_tlast  <= skid_last;
        m_axis_tuser  <= skid_user;
        skid_valid    <= 1'b0;
      end else begin
        m_axis_tvalid <= accept;
        if (accept) begin
          m_axis_tdata <= s_axis_tdata;
          m_axis_tlast <= s_axis_tlast;
          m_axis_tuser <= s_axis_tuser;
        end
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= s_axis_tdata;
      skid_last  <= s_axis_tlast;
      skid_user  <= s_axis_tuser;
    end
  end

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] idx;
  logic          early_sof;
  logic          no_sof;
  logic          in_beat;
  logic          close;
  logic          close_ok;
  logic [3:0]    new_err;

  assign early_sof = accept && s_axis_tuser && (state_q == FRAME);
  assign no_sof    = accept && !s_axis_tuser && (state_q == IDLE);
  assign in_beat   = accept && !early_sof && !no_sof;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // idx is the 0-based position of the current beat within its frame.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    close    = 1'b0;
    close_ok = 1'b0;
    new_err  = '0;
    idx      = s_axis_tuser ? '0 : cnt_q;
    unique case (1'b1)
      early_sof: begin
        new_err[1] = 1'b1;
        close      = 1'b1;
        state_d    = FRAME;
        cnt_d      = CW'(1);
      end
      no_sof: new_err[0] = 1'b1;
      in_beat: begin
        if (s_axis_tlast) begin
          close      = 1'b1;
          close_ok   = (idx == LAST);
          new_err[2] = (idx != LAST);
          state_d    = IDLE;
          cnt_d      = '0;
        end else if (idx == LAST) begin
          new_err[3] = 1'b1;
          close      = 1'b1;
          state_d    = IDLE;
          cnt_d      = '0;
        end else begin
          state_d = FRAME;
          cnt_d   = idx + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_flags   <= '0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      frame_count <= '0;
    end else begin
      err_flags  <= (clear_err ? 4'b0 : err_flags) | new_err;
      frame_done <= close;
      frame_ok   <= close && close_ok;
      if (close && close_ok)
        frame_count <= frame_count + 16'd1;
    end
  end

`ifdef FRAME_CHECKSUM_EN
  logic [31:0] acc_q;
  logic [31:0] px;
  logic [31:0] sum_in;

  assign px     = 32'(s_axis_tdata);
  assign sum_in = (s_axis_tuser ? 32'd0 : acc_q) + px;

  // An early SOF closes the old frame with the sum before this beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q          <= '0;
      frame_checksum <= '0;
    end else if (early_sof) begin
      frame_checksum <= acc_q;
      acc_q          <= px;
    end else if (in_beat) begin
      acc_q <= sum_in;
      if (close)
        frame_checksum <= sum_in;
    end
  end
`else
  assign frame_checksum = 32'd0;
`endif

endmodule

// File: tb/tb_axis_frame_checker.sv
// tb_axis_frame_checker: random-stimulus bench for axis_frame_checker
// with a beat-list reference model of the framing rules.
module tb_axis_frame_checker;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int DW = 24;
`ifdef FRAME_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  typedef struct packed {
    logic          user;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct packed {
    logic        ok;
    logic [31:0] sum;
  } close_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_user = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_user;
  logic          m_ready = 1'b1;
  logic          clear_err = 1'b0;
  logic [3:0]    err_flags;
  logic          frame_done;
  logic          frame_ok;
  logic [15:0]   frame_count;
  logic [31:0]   frame_checksum;

  always #5 clk = ~clk;

  axis_frame_checker #(
    .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid),
    .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid),
    .m_axis_tlast(m_last), .m_axis_tuser(m_user),
    .m_axis_tready(m_ready),
    .clear_err(clear_err), .err_flags(err_flags),
    .frame_done(frame_done), .frame_ok(frame_ok),
    .frame_count(frame_count),
    .frame_checksum(frame_checksum)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  beat_t  got_q[$];
  int     in_cyc[$];
  int     out_cyc[$];
  close_t done_q[$];
  int     done_cyc[$];
  int     lo_run;
  int     lo_max;
  int     unstable;
  logic   pend;
  beat_t  pend_b;

  always @(negedge clk) begin
    if (rst) begin
      got_q.delete(); in_cyc.delete(); out_cyc.delete();
      done_q.delete(); done_cyc.delete();
      lo_run <= 0; lo_max <= 0; unstable <= 0; pend <= 1'b0;
    end else begin
      if (s_valid && s_ready) in_cyc.push_back(cyc);
      if (pend && (m_valid !== 1'b1 ||
          {m_user, m_last, m_data} !== pend_b))
        unstable <= unstable + 1;
      pend   <= m_valid && !m_ready;
      pend_b <= {m_user, m_last, m_data};
      if (m_valid && m_ready) begin
        got_q.push_back({m_user, m_last, m_data});
        out_cyc.push_back(cyc);
      end
      if (!s_ready) begin
        lo_run <= lo_run + 1;
        if (lo_run + 1 > lo_max) lo_max <= lo_run + 1;
      end else lo_run <= 0;
      if (frame_done) begin
        done_q.push_back({frame_ok, frame_checksum});
        done_cyc.push_back(cyc);
      end
    end
  end

  beat_t       stim[$];
  beat_t       batch[$];
  logic [3:0]  exp_err;
  close_t      exp_done[$];
  logic [15:0] exp_cnt;

  function automatic logic [31:0] ck(input logic [31:0] s);
    return s & {32{CK_EN}};
  endfunction

  // Walks the accepted beat list as frames of N pixels.
  task automatic model();
    bit          inf = 1'b0;
    int          pos = 0;
    logic [31:0] sum = '0;
    exp_err = '0; exp_cnt = '0; exp_done.delete();
    foreach (stim[k]) begin
      if (stim[k].user && inf) begin
        exp_err[1] = 1'b1;
        exp_done.push_back({1'b0, ck(sum)});
        pos = 0; sum = 32'(stim[k].data);
        continue;
      end
      if (stim[k].user) begin
        inf = 1'b1; pos = 0; sum = 32'(stim[k].data);
      end else if (!inf) begin
        exp_err[0] = 1'b1;
        continue;
      end else begin
        pos++; sum += 32'(stim[k].data);
      end
      if (stim[k].last) begin
        if (pos != N - 1) exp_err[2] = 1'b1;
        else exp_cnt++;
        exp_done.push_back({pos == N - 1, ck(sum)});
        inf = 1'b0;
      end else if (pos == N - 1) begin
        exp_err[3] = 1'b1;
        exp_done.push_back({1'b0, ck(sum)});
        inf = 1'b0;
      end
    end
  endtask

  task automatic add_frame(input int len, input int last_at,
                           input int sof2_at, input bit user0);
    for (int k = 0; k < len; k++) begin
      beat_t b;
      b.user = (k == 0 && user0) || (k == sof2_at);
      b.last = (k == last_at);
      b.data = DW'($urandom());
      batch.push_back(b);
      stim.push_back(b);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1; clear_err = 1'b0;
    stim.delete(); batch.delete();
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0; #1;
  endtask

  // rmode: 0 ready high, 1 ready toggling, 2 ready random.
  task automatic run_batch(input int rmode, input int vpct);
    int i = 0;
    int guard = 0;
    bit hold = 1'b0;
    bit tg = 1'b1;
    bit acc;
    while (i < batch.size() && guard < 2000) begin
      m_ready = (rmode == 0) ? 1'b1 :
                (rmode == 1) ? tg : 1'($urandom_range(0, 1));
      tg = ~tg;
      if (!hold) hold = ($urandom_range(0, 99) < vpct);
      s_valid = hold;
      {s_user, s_last, s_data} = batch[i];
      acc = hold && s_ready;
      @(posedge clk); #1;
      guard++;
      if (acc) begin i++; hold = 1'b0; end
    end
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    batch.delete();
    if (guard >= 2000) begin
      n_tests++; n_fail++;
      $display("FAIL run_timeout got %0d beats exp %0d", i, batch.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    n_tests++;
    if (s_ready !== 1'b0) begin n_fail++;
      $display("FAIL rst_ready got %b exp 0", s_ready); end
    n_tests++;
    if ({m_valid, m_last, m_user, m_data} !== '0) begin n_fail++;
      $display("FAIL rst_m got %h exp 0", {m_valid, m_last, m_user, m_data}); end
    n_tests++;
    if ({err_flags, frame_done, frame_ok, frame_count, frame_checksum} !== '0) begin
      n_fail++;
      $display("FAIL rst_stat got %h exp 0",
               {err_flags, frame_done, frame_ok, frame_count, frame_checksum});
    end
    rst = 1'b0; #1;
    n_tests++;
    if (s_ready !== 1'b1) begin n_fail++;
      $display("FAIL rst_ready_after got %b exp 1", s_ready); end
  endtask

  task automatic test_basic_frame();
    beat_t g;
    apply_reset();
    add_frame(8, 7, -1, 1'b1);
    run_batch(0, 100);
    model();
    n_tests++;
    if (got_q.size() !== stim.size()) begin n_fail++;
      $display("FAIL basic_len got %0d exp %0d", got_q.size(), stim.size()); end
    foreach (stim[k]) begin
      g = (k < got_q.size()) ? got_q[k] : 'x;
      n_tests++;
      if (g !== stim[k]) begin n_fail++;
        $display("FAIL basic_beat%0d got %h exp %h", k, g, stim[k]); end
      n_tests++;
      if (k >= out_cyc.size() || out_cyc[k] - in_cyc[k] !== 1) begin n_fail++;
        $display("FAIL basic_lat%0d exp 1", k); end
    end
    n_tests++;
    if (done_q.size() !== 1 || done_q[0] !== exp_done[0]) begin n_fail++;
      $display("FAIL basic_done got %0d closes exp 1 ok", done_q.size()); end
    n_tests++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== in_cyc[7] + 1) begin n_fail++;
      $display("FAIL basic_done_cyc exp %0d", in_cyc[7] + 1); end
    n_tests++;
    if ({frame_count, err_flags} !== {16'd1, 4'b0}) begin n_fail++;
      $display("FAIL basic_stat got %h/%b exp 1/0", frame_count, err_flags); end
  endtask

  task automatic test_backpressure();
    beat_t g;
    apply_reset();
    add_frame(8, 7, -1, 1'b1);
    run_batch(1, 100);
    model();
    n_tests++;
    if (got_q.size() !== stim.size()) begin n_fail++;
      $display("FAIL bp_len got %0d exp %0d", got_q.size(), stim.size()); end
    foreach (stim[k]) begin
      g = (k < got_q.size()) ? got_q[k] : 'x;
      n_tests++;
      if (g !== stim[k]) begin n_fail++;
        $display("FAIL bp_beat%0d got %h exp %h", k, g, stim[k]); end
    end
    n_tests++;
    if (lo_max > 1) begin n_fail++;
      $display("FAIL bp_ready_low got %0d cycles exp <=1", lo_max); end
    n_tests++;
    if (unstable !== 0) begin n_fail++;
      $display("FAIL bp_stable got %0d changes exp 0", unstable); end
    n_tests++;
    if (frame_count !== exp_cnt) begin n_fail++;
      $display("FAIL bp_count got %0d exp %0d", frame_count, exp_cnt); end
  endtask

  task automatic test_early_eof();
    apply_reset();
    add_frame(6, 5, -1, 1'b1);
    run_batch(0, 100);
    model();
    n_tests++;
    if (err_flags !== 4'b0100) begin n_fail++;
      $display("FAIL eeof_err got %b exp 0100", err_flags); end
    n_tests++;
    if (done_q.size() !== 1 || done_q[0].ok !== 1'b0) begin n_fail++;
      $display("FAIL eeof_done got %0d closes exp 1 bad", done_q.size()); end
    n_tests++;
    if (frame_count !== 16'd0) begin n_fail++;
      $display("FAIL eeof_count got %0d exp 0", frame_count); end
    add_frame(8, 7, -1, 1'b1);
    run_batch(2, 80);
    model();
    n_tests++;
    if (frame_count !== exp_cnt) begin n_fail++;
      $display("FAIL eeof_count2 got %0d exp %0d", frame_count, exp_cnt); end
    n_tests++;
    if (done_q.size() !== 2 || done_q[1] !== exp_done[1]) begin n_fail++;
      $display("FAIL eeof_done2 got %0d closes exp 2", done_q.size()); end
  endtask

  task automatic test_missing_eof();
    apply_reset();
    add_frame(9, -1, -1, 1'b1);
    add_frame(8, 7, -1, 1'b1);
    run_batch(0, 100);
    model();
    n_tests++;
    if (err_flags !== 4'b1001 || err_flags !== exp_err) begin n_fail++;
      $display("FAIL meof_err got %b exp 1001", err_flags); end
    n_tests++;
    if (done_cyc.size() < 1 || done_cyc[0] !== in_cyc[7] + 1) begin n_fail++;
      $display("FAIL meof_done_cyc exp %0d", in_cyc[7] + 1); end
    n_tests++;
    if (frame_count !== 16'd1) begin n_fail++;
      $display("FAIL meof_count got %0d exp 1", frame_count); end
    clear_err = 1'b1; @(posedge clk); #1; clear_err = 1'b0;
    n_tests++;
    if (err_flags !== 4'b0) begin n_fail++;
      $display("FAIL clr_err got %b exp 0000", err_flags); end
    add_frame(3, 2, -1, 1'b1);
    run_batch(0, 100);
    s_valid = 1'b1; s_user = 1'b0; s_last = 1'b0; clear_err = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; clear_err = 1'b0;
    n_tests++;
    if (err_flags !== 4'b0001) begin n_fail++;
      $display("FAIL clr_same_cycle got %b exp 0001", err_flags); end
  endtask

  task automatic test_early_sof();
    apply_reset();
    add_frame(3, -1, -1, 1'b1);
    add_frame(8, 7, -1, 1'b1);
    run_batch(2, 90);
    model();
    n_tests++;
    if (err_flags !== 4'b0010) begin n_fail++;
      $display("FAIL esof_err got %b exp 0010", err_flags); end
    n_tests++;
    if (done_q.size() !== 2 || done_q[0] !== exp_done[0] ||
        done_q[1] !== exp_done[1]) begin n_fail++;
      $display("FAIL esof_done got %0d closes exp bad,ok", done_q.size()); end
    n_tests++;
    if (frame_count !== 16'd1) begin n_fail++;
      $display("FAIL esof_count got %0d exp 1", frame_count); end
  endtask

  task automatic test_checksum_reset();
    beat_t b;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      b.user = (k == 0); b.last = (k == 7); b.data = DW'(k + 1);
      batch.push_back(b); stim.push_back(b);
    end
    run_batch(0, 100);
    n_tests++;
    if (done_q.size() !== 1 || done_q[0] !== {1'b1, ck(32'h24)}) begin
      n_fail++;
      $display("FAIL cks_sum got %h exp %h", frame_checksum, ck(32'h24));
    end
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1; s_user = (k == 0); s_last = 1'b0; s_data = DW'(k + 1);
      @(posedge clk); #1;
    end
    rst = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({s_ready, m_valid, frame_done, frame_count, frame_checksum, err_flags}
        !== '0) begin n_fail++;
      $display("FAIL mid_rst got %b/%b/%0d/%h", s_ready, m_valid,
               frame_count, frame_checksum); end
    rst = 1'b0; m_ready = 1'b1; stim.delete();
    repeat (3) begin @(posedge clk); #1; end
    n_tests++;
    if (done_q.size() !== 0 || got_q.size() !== 0) begin n_fail++;
      $display("FAIL mid_rst_flush got %0d closes %0d beats exp 0",
               done_q.size(), got_q.size()); end
    add_frame(8, 7, -1, 1'b1);
    run_batch(0, 100);
    model();
    n_tests++;
    if (done_q.size() !== 1 || done_q[0] !== exp_done[0]) begin n_fail++;
      $display("FAIL post_rst_frame got %0d closes exp 1 ok", done_q.size()); end
  endtask

  task automatic test_random();
    beat_t g;
    int len;
    apply_reset();
    for (int f = 0; f < 12; f++) begin
      len = $urandom_range(1, 11);
      add_frame(len,
                ($urandom_range(0, 3) != 0) ? len - 1 : -1,
                ($urandom_range(0, 5) == 0) ? $urandom_range(1, len) : -1,
                ($urandom_range(0, 7) != 0));
    end
    run_batch(2, 70);
    model();
    n_tests++;
    if (got_q.size() !== stim.size()) begin n_fail++;
      $display("FAIL rnd_len got %0d exp %0d", got_q.size(), stim.size()); end
    foreach (stim[k]) begin
      g = (k < got_q.size()) ? got_q[k] : 'x;
      n_tests++;
      if (g !== stim[k]) begin n_fail++;
        $display("FAIL rnd_beat%0d got %h exp %h", k, g, stim[k]); end
    end
    n_tests++;
    if (done_q.size() !== exp_done.size()) begin n_fail++;
      $display("FAIL rnd_ncl got %0d exp %0d", done_q.size(), exp_done.size()); end
    foreach (exp_done[k]) begin
      n_tests++;
      if (k >= done_q.size() || done_q[k] !== exp_done[k]) begin n_fail++;
        $display("FAIL rnd_close%0d exp %h", k, exp_done[k]); end
    end
    n_tests++;
    if ({err_flags, frame_count} !== {exp_err, exp_cnt}) begin n_fail++;
      $display("FAIL rnd_stat got %b/%0d exp %b/%0d",
               err_flags, frame_count, exp_err, exp_cnt); end
    n_tests++;
    if (unstable !== 0) begin n_fail++;
      $display("FAIL rnd_stable got %0d exp 0", unstable); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_early_eof();
    test_missing_eof();
    test_early_sof();
    test_checksum_reset();
    for (int r = 0; r < 4; r++) test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
